// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and fault-classification helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 64;
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // Stores only know B/H/W; loads reject the three unused encodings.
    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        if (store) begin
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halves need even addresses, words need 4-byte alignment.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
               ((f3 == F3_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus of the load/store unit.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        access_fault;

    modport master (
        output req_valid, is_store, funct3, addr, store_data,
        input  req_ready, resp_valid, load_data, misaligned, access_fault
    );

    modport slave (
        input  req_valid, is_store, funct3, addr, store_data,
        output req_ready, resp_valid, load_data, misaligned, access_fault
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half and extend it according to the access type.
    always_comb begin
        byte_sel    = rdata_i[7:0];
        half_sel    = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_data_o = '0;
        case (lane_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            F3_W:    load_data_o = rdata_i;
            default: load_data_o = '0;
        endcase
    end

    // Replace only the addressed lane of the old word with the store operand.
    always_comb begin
        merge_data_o = rdata_i;
        case (funct3_i)
            F3_B: begin
                case (lane_i)
                    2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_data_o[23:16] = wdata_i[7:0];
                    default: merge_data_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: begin
                if (lane_i[1]) merge_data_o[31:16] = wdata_i[15:0];
                else           merge_data_o[15:0]  = wdata_i[15:0];
            end
            F3_W:    merge_data_o = wdata_i;
            default: merge_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks faults, runs the memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
)(
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus,
    output logic               mem_read,
    output logic               mem_write,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    lsu_state_e  state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] store_data_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] load_data_q;
    logic        misaligned_q;
    logic        access_fault_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        illegal_c;
    logic        oob_c;
    logic        misal_c;
    logic [31:0] load_ext_c;
    logic [31:0] merge_c;

    // Fault classification of the request currently on the bus.
    assign illegal_c = f3_illegal(bus.is_store, bus.funct3);
    assign oob_c     = ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS));
    assign misal_c   = f3_misaligned(bus.funct3, bus.addr[1:0]);

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .lane_i       (lane_q),
        .rdata_i      (mem_rdata),
        .wdata_i      (store_data_q),
        .load_data_o  (load_ext_c),
        .merge_data_o (merge_c)
    );

    // Request FSM with registered bus and memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            funct3_q       <= '0;
            lane_q         <= '0;
            store_data_q   <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            load_data_q    <= '0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q       <= bus.funct3;
                        lane_q         <= bus.addr[1:0];
                        store_data_q   <= bus.store_data;
                        mem_addr_q     <= {2'b00, bus.addr[31:2]};
                        req_ready_q    <= 1'b0;
                        load_data_q    <= '0;
                        misaligned_q   <= 1'b0;
                        access_fault_q <= 1'b0;
                        if (illegal_c || oob_c) begin
                            access_fault_q <= 1'b1;
                            resp_valid_q   <= 1'b1;
                            state_q        <= RESP;
                        end else if (misal_c) begin
                            misaligned_q   <= 1'b1;
                            resp_valid_q   <= 1'b1;
                            state_q        <= RESP;
                        end else if (!bus.is_store) begin
                            mem_read_q     <= 1'b1;
                            state_q        <= LOAD;
                        end else if (bus.funct3 == F3_W) begin
                            mem_write_q    <= 1'b1;
                            mem_wdata_q    <= bus.store_data;
                            state_q        <= WRITE;
                        end else begin
                            mem_read_q     <= 1'b1;
                            state_q        <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    load_data_q  <= load_ext_c;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RMW_RD: begin
                    mem_wdata_q  <= merge_c;
                    mem_write_q  <= 1'b1;
                    state_q      <= WRITE;
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    load_data_q    <= '0;
                    misaligned_q   <= 1'b0;
                    access_fault_q <= 1'b0;
                    req_ready_q    <= 1'b1;
                    state_q        <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.load_data    = load_data_q;
    assign bus.misaligned   = misaligned_q;
    assign bus.access_fault = access_fault_q;
    assign mem_read         = mem_read_q;
    assign mem_write        = mem_write_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 64: number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit accepts a request this cycle.
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address.
REQ-009 store_data  input  32  store operand; uses low byte or half for sub-word stores.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 load_data  output  32  extended load result; valid while resp_valid is high.
REQ-012 misaligned  output  1  fault flag, valid with resp_valid.
REQ-013 access_fault  output  1  fault flag (illegal funct3 or out of range), valid with resp_valid.
REQ-014 mem_read  output  1  read enable to the data memory.
REQ-015 mem_write  output  1  write enable to the data memory.
REQ-016 mem_addr  output  32  word index, equal to {2'b00, addr[31:2]}.
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  combinational read data from the memory.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RMW_RD, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A handshake (req_valid & req_ready) in IDLE SHALL register is_store, funct3, addr and store_data; inputs are ignored at all other times.
REQ-021 Fault checks SHALL run at accept, in this priority order:
  - Illegal funct3 (load 011/110/111; store anything other than 000/001/010) → access_fault.
  - Word index ≥ MEM_WORDS → access_fault.
  - Halfword with addr[0]=1, or word with addr[1:0]≠0 → misaligned.
  - On any fault: IDLE→RESP with no memory access; response 1 cycle after accept.
REQ-022 Load path: IDLE→LOAD→RESP.
  - LOAD asserts mem_read and registers mem_rdata.
  - resp_valid is asserted 2 cycles after accept.
REQ-023 Load extraction SHALL use lane addr[1:0] for bytes and addr[1] for halves.
  - B and H are sign-extended; BU and HU are zero-extended; W is passed through.
REQ-024 Word store: IDLE→WRITE→RESP.
  - WRITE asserts mem_write with mem_wdata=store_data.
  - resp_valid is asserted 2 cycles after accept.
REQ-025 Sub-word store (read-modify-write): IDLE→RMW_RD→WRITE→RESP.
  - RMW_RD asserts mem_read and registers mem_rdata.
  - WRITE replaces only the addressed byte or half.
  - resp_valid is asserted 3 cycles after accept.
REQ-026 RESP SHALL pulse resp_valid for exactly one cycle, then return to IDLE.
  - A new request is accepted no earlier than the cycle after RESP.
REQ-027 mem_read and mem_write SHALL never be high together, and both SHALL be 0 in IDLE and RESP.
REQ-028 In a store response, load_data SHALL be 0; in a fault response, load_data SHALL be 0 and mem_write SHALL never have been asserted for that request.

Reset
REQ-029 Reset SHALL force IDLE and drive all outputs to 0 except req_ready, which is 1 after release.
REQ-030 Reset mid-operation (including in RMW_RD) SHALL abort the request: no mem_write after reset and no resp_valid for that request.

Structure
REQ-031 Package lsu_pkg SHALL hold:
  - the funct3 encodings;
  - the FSM state enum;
  - the default MEM_WORDS constant.
REQ-032 Byte-lane extract/extend and merge logic SHALL live in a combinational sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-033 Word load: mem[5]=0x8000_00F0; LW addr=0x14 → resp_valid 2 cycles after accept, load_data=0x8000_00F0.
REQ-034 Sign vs zero extension: LB addr=0x14 → 0xFFFF_FFF0; LBU → 0x0000_00F0; LH addr=0x16 → 0xFFFF_8000.
REQ-035 Sub-word store: mem[3]=0x1122_3344; SB addr=0x0D, data=0xAB → exactly one mem_write with word 0x1122_AB44; resp 3 cycles after accept.
REQ-036 Faults:
  - LW addr=0x02 → misaligned=1, no mem_read/mem_write, resp 1 cycle after accept.
  - SW addr=0x100 with MEM_WORDS=64 → access_fault=1.
  - funct3=011 → access_fault=1.
REQ-037 Back-to-back requests with req_valid held high: req_ready low from accept through RESP; the second request is accepted in the cycle after RESP.
REQ-038 Reset asserted during RMW_RD of an SH → no mem_write, no resp_valid; req_ready=1 after release.
